// File: rtl/cnt_check.sv
// rtl/cnt_check.sv - loopback count checker: sends N, then expects bytes 0..N back
module cnt_check #(
    parameter int TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activate,
    input  logic [7:0] count_in,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] err_count,
    output logic [8:0] rx_total,
    input  logic       tx_done,
    input  logic       tx_active,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_start
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_WAIT_TX = 3'd2,
        S_RECV    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        r_state;
    logic [7:0]    r_n;
    logic [7:0]    r_expected;
    logic [TW-1:0] r_timer;
    logic          r_done;
    logic          r_pass;
    logic          r_timeout;
    logic [7:0]    r_err;
    logic [8:0]    r_rx_total;
    logic [7:0]    r_tx_data;
    logic          r_tx_start;

    logic       w_mismatch;
    logic [7:0] w_err_next;
    logic       w_last;
    logic       w_expire;

    assign w_mismatch = (rx_data != r_expected);
    assign w_err_next = (w_mismatch && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
    // The byte whose index equals N closes the run whatever its value.
    assign w_last     = (r_expected == r_n);
    assign w_expire   = (r_timer == TLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_n        <= 8'd0;
            r_expected <= 8'd0;
            r_timer    <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= 8'd0;
            r_rx_total <= 9'd0;
            r_tx_data  <= 8'd0;
            r_tx_start <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done     <= 1'b0;
                    r_tx_start <= 1'b0;
                    if (activate && !tx_active) begin
                        r_n        <= count_in;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_err      <= 8'd0;
                        r_rx_total <= 9'd0;
                        r_tx_data  <= count_in;
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    r_tx_start <= 1'b0;
                    if (tx_done) begin
                        r_expected <= 8'd0;
                        r_timer    <= '0;
                        r_state    <= S_RECV;
                    end
                end
                S_RECV: begin
                    // A byte arriving on the expiry cycle wins and restarts the timer.
                    if (rx_ready) begin
                        r_rx_total <= r_rx_total + 9'd1;
                        r_err      <= w_err_next;
                        r_expected <= r_expected + 8'd1;
                        r_timer    <= '0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 8'd0);
                            r_state <= S_DONE;
                        end
                    end else if (w_expire) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DONE: begin
                    r_tx_start <= 1'b0;
                    if (!activate && !rx_ready && !tx_active) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_done     <= 1'b0;
                    r_tx_start <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign err_count = r_err;
    assign rx_total  = r_rx_total;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;

endmodule
